mem_port_arbiter: RTL and testbench

//  Shares the core's single memory port (mem_addr/mem_data_out/mem_data_in/mem_read_en/
//  mem_write_en) between the instruction-fetch (IF) and load/store (LS) requesters.

---
 rtl/mem_port_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and load/store requesters.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is fixed priority (LS wins).
module mem_port_arbiter #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [AWIDTH-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [DWIDTH-1:0] if_rsp_data,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [AWIDTH-1:0] ls_req_addr,
  input  logic              ls_req_we,
  input  logic [DWIDTH-1:0] ls_req_wdata,
  output logic              ls_rsp_valid,
  output logic [DWIDTH-1:0] ls_rsp_data,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_data_out,
  input  logic [DWIDTH-1:0] mem_data_in,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [3:0] LP_RD_LAT = 4'(RD_LAT);

  state_t            r_state;
  state_t            w_next;
  logic              w_gnt_if;
  logic              w_gnt_ls;
  logic              w_hs_if;
  logic              w_hs_ls;
  logic              w_wait_done;
  logic              r_we;
  logic              r_owner_ls;
  logic [3:0]        r_cnt;
  logic              r_busy;
  logic [AWIDTH-1:0] r_mem_addr;
  logic [DWIDTH-1:0] r_mem_data_out;
  logic              r_mem_read_en;
  logic              r_mem_write_en;
  logic              r_if_rsp_valid;
  logic              r_ls_rsp_valid;
  logic [DWIDTH-1:0] r_if_rsp_data;
  logic [DWIDTH-1:0] r_ls_rsp_data;

`ifdef MEM_ARB_RR_EN
  // r_last_ls=1 means LS won the last handshake, so a tie goes to IF (reset favours IF).
  logic r_last_ls;

  always_comb begin
    w_gnt_if = 1'b0;
    w_gnt_ls = 1'b0;
    if (if_req_valid && ls_req_valid) begin
      w_gnt_if = r_last_ls;
      w_gnt_ls = ~r_last_ls;
    end else begin
      w_gnt_if = if_req_valid;
      w_gnt_ls = ls_req_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_ls <= 1'b1;
    end else if (w_hs_ls) begin
      r_last_ls <= 1'b1;
    end else if (w_hs_if) begin
      r_last_ls <= 1'b0;
    end else begin
      r_last_ls <= r_last_ls;
    end
  end
`else
  always_comb begin
    w_gnt_ls = ls_req_valid;
    w_gnt_if = if_req_valid & ~ls_req_valid;
  end
`endif

  assign if_req_ready = (r_state == S_IDLE) & w_gnt_if;
  assign ls_req_ready = (r_state == S_IDLE) & w_gnt_ls;
  assign w_hs_if      = if_req_ready & if_req_valid;
  assign w_hs_ls      = ls_req_ready & ls_req_valid;
  assign w_wait_done  = (r_state == S_WAIT) && (r_cnt <= 4'd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_hs_if || w_hs_ls) begin
          w_next = S_ACCESS;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (r_we) begin
          w_next = S_RESP;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_wait_done) begin
          w_next = S_RESP;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Memory strobes and responses are registered so they are live only in ACCESS / RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_we           <= 1'b0;
      r_owner_ls     <= 1'b0;
      r_cnt          <= 4'd0;
      r_mem_addr     <= {AWIDTH{1'b0}};
      r_mem_data_out <= {DWIDTH{1'b0}};
      r_mem_read_en  <= 1'b0;
      r_mem_write_en <= 1'b0;
      r_if_rsp_valid <= 1'b0;
      r_ls_rsp_valid <= 1'b0;
      r_if_rsp_data  <= {DWIDTH{1'b0}};
      r_ls_rsp_data  <= {DWIDTH{1'b0}};
    end else begin
      r_state        <= w_next;
      r_busy         <= (w_next != S_IDLE);
      r_mem_addr     <= {AWIDTH{1'b0}};
      r_mem_data_out <= {DWIDTH{1'b0}};
      r_mem_read_en  <= 1'b0;
      r_mem_write_en <= 1'b0;
      r_if_rsp_valid <= 1'b0;
      r_ls_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hs_ls) begin
            r_owner_ls     <= 1'b1;
            r_we           <= ls_req_we;
            r_mem_addr     <= ls_req_addr;
            r_mem_read_en  <= ~ls_req_we;
            r_mem_write_en <= ls_req_we;
            r_mem_data_out <= ls_req_we ? ls_req_wdata : {DWIDTH{1'b0}};
          end else if (w_hs_if) begin
            r_owner_ls    <= 1'b0;
            r_we          <= 1'b0;
            r_mem_addr    <= if_req_addr;
            r_mem_read_en <= 1'b1;
          end else begin
            r_owner_ls <= r_owner_ls;
          end
        end
        S_ACCESS: begin
          r_cnt <= LP_RD_LAT;
          if (r_we) begin
            if (r_owner_ls) begin
              r_ls_rsp_valid <= 1'b1;
              r_ls_rsp_data  <= {DWIDTH{1'b0}};
            end else begin
              r_if_rsp_valid <= 1'b1;
              r_if_rsp_data  <= {DWIDTH{1'b0}};
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_wait_done) begin
            if (r_owner_ls) begin
              r_ls_rsp_valid <= 1'b1;
              r_ls_rsp_data  <= mem_data_in;
            end else begin
              r_if_rsp_valid <= 1'b1;
              r_if_rsp_data  <= mem_data_in;
            end
          end
        end
        S_RESP: begin
          r_cnt <= 4'd0;
        end
        default: begin
          r_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign mem_addr     = r_mem_addr;
  assign mem_data_out = r_mem_data_out;
  assign mem_read_en  = r_mem_read_en;
  assign mem_write_en = r_mem_write_en;
  assign if_rsp_valid = r_if_rsp_valid;
  assign if_rsp_data  = r_if_rsp_data;
  assign ls_rsp_valid = r_ls_rsp_valid;
  assign ls_rsp_data  = r_ls_rsp_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance at RD_LAT=1 and one at RD_LAT=4, selected by sel4.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        sel4;
  logic        if_valid, ls_valid, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  int          ovr_cyc = -1;
  logic [31:0] ovr_val = 32'h0;
  logic [31:0] mem_rdata;

  // Memory model: a per-cycle pattern, with one cycle optionally overridden.
  assign mem_rdata = (cyc == ovr_cyc) ? ovr_val : (32'hC0DE0000 + 32'(cyc));

  logic        d1_if_ready, d1_ls_ready, d1_if_rv, d1_ls_rv, d1_rd, d1_wr, d1_busy;
  logic [31:0] d1_if_data, d1_ls_data, d1_addr, d1_dout;
  logic        d4_if_ready, d4_ls_ready, d4_if_rv, d4_ls_rv, d4_rd, d4_wr, d4_busy;
  logic [31:0] d4_if_data, d4_ls_data, d4_addr, d4_dout;

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_valid & ~sel4), .if_req_ready(d1_if_ready), .if_req_addr(if_addr),
    .if_rsp_valid(d1_if_rv), .if_rsp_data(d1_if_data),
    .ls_req_valid(ls_valid & ~sel4), .ls_req_ready(d1_ls_ready), .ls_req_addr(ls_addr),
    .ls_req_we(ls_we), .ls_req_wdata(ls_wdata),
    .ls_rsp_valid(d1_ls_rv), .ls_rsp_data(d1_ls_data),
    .mem_addr(d1_addr), .mem_data_out(d1_dout), .mem_data_in(mem_rdata),
    .mem_read_en(d1_rd), .mem_write_en(d1_wr), .busy(d1_busy)
  );

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .RD_LAT(4)) dut4 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_valid & sel4), .if_req_ready(d4_if_ready), .if_req_addr(if_addr),
    .if_rsp_valid(d4_if_rv), .if_rsp_data(d4_if_data),
    .ls_req_valid(ls_valid & sel4), .ls_req_ready(d4_ls_ready), .ls_req_addr(ls_addr),
    .ls_req_we(ls_we), .ls_req_wdata(ls_wdata),
    .ls_rsp_valid(d4_ls_rv), .ls_rsp_data(d4_ls_data),
    .mem_addr(d4_addr), .mem_data_out(d4_dout), .mem_data_in(mem_rdata),
    .mem_read_en(d4_rd), .mem_write_en(d4_wr), .busy(d4_busy)
  );

  logic        w_if_ready, w_ls_ready, w_if_rv, w_ls_rv, w_rd, w_wr, w_busy;
  logic [31:0] w_if_data, w_ls_data, w_addr, w_dout;
  assign w_if_ready = sel4 ? d4_if_ready : d1_if_ready;
  assign w_ls_ready = sel4 ? d4_ls_ready : d1_ls_ready;
  assign w_if_rv    = sel4 ? d4_if_rv    : d1_if_rv;
  assign w_ls_rv    = sel4 ? d4_ls_rv    : d1_ls_rv;
  assign w_if_data  = sel4 ? d4_if_data  : d1_if_data;
  assign w_ls_data  = sel4 ? d4_ls_data  : d1_ls_data;
  assign w_rd       = sel4 ? d4_rd       : d1_rd;
  assign w_wr       = sel4 ? d4_wr       : d1_wr;
  assign w_addr     = sel4 ? d4_addr     : d1_addr;
  assign w_dout     = sel4 ? d4_dout     : d1_dout;
  assign w_busy     = sel4 ? d4_busy     : d1_busy;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          ls;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  // Scoreboard: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (w_if_rv || w_ls_rv) begin
      check("rsp_expected", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("rsp_one_hot", 64'(w_if_rv & w_ls_rv), 64'd0);
        check("rsp_port_ls", 64'(w_ls_rv), 64'(e.ls));
        check("rsp_data", e.ls ? w_ls_data : w_if_data, e.data);
        check("rsp_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  typedef struct {
    bit          ls;
    bit          we;
    bit          sel4;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          exp_off;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vt[7];

  int t_hs;
  int hs_wait;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ovr_cyc = -1;
  endtask

  task automatic apply(input vec_t v);
    bit got = 1'b0;
    sel4 = v.sel4;
    hs_wait = -1;
    if (v.ls) begin
      ls_valid = 1'b1; ls_addr = v.addr; ls_we = v.we; ls_wdata = v.wdata;
    end else begin
      if_valid = 1'b1; if_addr = v.addr;
    end
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (v.ls ? w_ls_ready : w_if_ready) begin
        got = 1'b1; hs_wait = w; t_hs = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("handshake", 64'(got), 64'd1);
    if (got) begin
      check("other_ready", 64'(v.ls ? w_if_ready : w_ls_ready), 64'd0);
      sbq.push_back('{v.ls, v.exp_data, t_hs + v.exp_off});
      ovr_cyc = t_hs + 1 + (v.sel4 ? 4 : 1);
      ovr_val = v.rdata;
    end
    @(posedge clk);
    #1;
    if_valid = 1'b0; ls_valid = 1'b0;
    if (got) begin
      for (int k = 1; k <= v.exp_off; k++) begin
        @(negedge clk);
        check("busy_high", 64'(w_busy), 64'd1);
        if (k == 1) begin
          check("access_rd", 64'(w_rd), 64'(!v.we));
          check("access_wr", 64'(w_wr), 64'(v.we));
          check("access_addr", w_addr, v.addr);
          check("access_dout", w_dout, v.we ? v.wdata : 32'h0);
        end else begin
          check("no_strobe", 64'({w_rd, w_wr}), 64'd0);
          check("mem_addr_zero", w_addr, 64'd0);
        end
      end
      @(negedge clk);
      check("busy_low", 64'(w_busy), 64'd0);
      check("rsp_drained", 64'(sbq.size()), 64'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [2:0] exp_ls;
    bit got;
    vec_t v6;

    vt[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 3, 32'hDEAD_BEEF};
    vt[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h1234_5678, 32'h0,         2, 32'h0};
    vt[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0204, 32'h0,         32'h0BAD_F00D, 3, 32'h0BAD_F00D};
    vt[3] = '{1'b0, 1'b0, 1'b0, 32'h0000_01FC, 32'h0,         32'hFFFF_FFFF, 3, 32'hFFFF_FFFF};
    vt[4] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 32'h0,         2, 32'h0};
    vt[5] = '{1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 6, 32'hCAFE_F00D};
    vt[6] = '{1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'h0,         32'h1357_9BDF, 6, 32'h1357_9BDF};

    sel4 = 1'b0; if_valid = 1'b0; ls_valid = 1'b0; ls_we = 1'b0;
    if_addr = 32'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
    do_reset();

    // Quiet after reset: nothing may move without requests.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_quiet", 64'({w_busy, w_rd, w_wr, w_if_ready, w_ls_ready, w_if_rv, w_ls_rv,
                               |w_addr, |w_dout, |w_if_data, |w_ls_data}), 64'd0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      apply(vt[i]);
      if (i < 2) check("grant_immediate", 64'(hs_wait), 64'd0);
    end

    // Response data holds between pulses on both instances.
    check("hold_if_lat4", 64'(w_if_data), 64'h1357_9BDF);
    check("hold_ls_lat4", 64'(w_ls_data), 64'hCAFE_F00D);
    sel4 = 1'b0;
    #1;
    check("hold_if_lat1", 64'(w_if_data), 64'hFFFF_FFFF);
    check("hold_ls_lat1", 64'(w_ls_data), 64'h0);

    // Simultaneous requests held across three grants.
    do_reset();
`ifdef MEM_ARB_RR_EN
    exp_ls = 3'b010;
`else
    exp_ls = 3'b111;
`endif
    if_valid = 1'b1; if_addr = 32'h300; ls_valid = 1'b1; ls_addr = 32'h400; ls_we = 1'b0;
    for (int g = 0; g < 3; g++) begin
      got = 1'b0;
      for (int w = 0; w < 20; w++) begin
        @(negedge clk);
        if (w_if_ready || w_ls_ready) begin
          got = 1'b1; t_hs = cyc;
          break;
        end
        @(posedge clk);
        #1;
      end
      check("arb_grant", 64'(got), 64'd1);
      if (!got) break;
      check("arb_one_ready", 64'(w_if_ready & w_ls_ready), 64'd0);
      check($sformatf("arb_grant%0d_ls", g), 64'(w_ls_ready), 64'(exp_ls[g]));
      sbq.push_back('{exp_ls[g], 32'hC0DE0000 + 32'(t_hs + 2), t_hs + 3});
      @(posedge clk);
      #1;
      if (g == 2) begin
        if_valid = 1'b0; ls_valid = 1'b0;
      end
    end
    if_valid = 1'b0; ls_valid = 1'b0;
    for (int w = 0; w < 20; w++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    check("arb_drain", 64'(sbq.size()), 64'd0);
    @(posedge clk);
    #1;

    // Reset during WAIT discards the read; a fresh IF request is granted at once.
    do_reset();
    sel4 = 1'b1; ls_valid = 1'b1; ls_addr = 32'h40; ls_we = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (w_ls_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("rst_seq_grant", 64'(got), 64'd1);
    @(posedge clk);
    #1 ls_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_busy", 64'(w_busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_outs", 64'({w_busy, w_rd, w_wr, w_if_rv, w_ls_rv, |w_addr}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    v6 = '{1'b0, 1'b0, 1'b1, 32'h0000_0500, 32'h0, 32'h2468_ACE0, 6, 32'h2468_ACE0};
    apply(v6);
    check("post_rst_grant_immediate", 64'(hs_wait), 64'd0);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
